// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the frame format encodings used by
// both uart_tnsm and uart_rcvr.
package uart_pkg;

    typedef enum logic [2:0] {
        STATE_RCVR_IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rcvr_state_t;

    typedef enum logic [1:0] {
        FRAME_5,
        FRAME_6,
        FRAME_7,
        FRAME_8
    } frame_t;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD,
        PARITY_NONE_ALT
    } parity_t;

    typedef enum logic {
        STOP_ONE,
        STOP_TWO
    } stop_t;

    function automatic logic parity_enabled(logic [1:0] ptype);
        return (ptype == PARITY_EVEN) || (ptype == PARITY_ODD);
    endfunction

    // Index of the final data bit for a given frame_type (5..8 bits).
    function automatic logic [2:0] last_index(logic [1:0] ftype);
        return 3'd4 + {1'b0, ftype};
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a configurable reset level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rcvr.sv
// UART receiver: oversamples the synchronised rx line, centre-samples each bit and reports
// the word with a one-cycle done strobe plus parity and framing error flags.
module uart_rcvr
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       active,
    input  logic       rcvr_clk_en,
    input  logic       rcvr_clr,
    input  logic       rx,
    input  logic [1:0] frame_type,
    input  logic [1:0] parity_type,
    input  logic       stop_type,
    output logic [7:0] data,
    output logic       done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    rcvr_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    cfg_frame_q, cfg_frame_d;
    logic [1:0]    cfg_parity_q, cfg_parity_d;
    logic          cfg_stop_q, cfg_stop_d;
    logic          perr_acc_q, perr_acc_d;
    logic          ferr_acc_q, ferr_acc_d;
    logic          armed_q, armed_d;
    logic [7:0]    data_q, data_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          done_q, done_d;
    logic          rx_s;
    logic          finish;
    logic          ferr_fin;

    uart_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk   (clk),
        .arst_n(arst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        cfg_frame_d  = cfg_frame_q;
        cfg_parity_d = cfg_parity_q;
        cfg_stop_d   = cfg_stop_q;
        perr_acc_d   = perr_acc_q;
        ferr_acc_d   = ferr_acc_q;
        armed_d      = armed_q;
        data_d       = data_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        done_d       = 1'b0;
        finish       = 1'b0;
        ferr_fin     = 1'b0;

        if (rcvr_clr || !active) begin
            state_d = STATE_RCVR_IDLE;
            cnt_d   = '0;
            if (rcvr_clr) begin
                data_d = '0;
                perr_d = 1'b0;
                ferr_d = 1'b0;
            end
        end else if (rcvr_clk_en) begin
            case (state_q)
                STATE_RCVR_IDLE: begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = '0;
                        if (!rx_s) begin
                            state_d      = DATA;
                            idx_d        = '0;
                            shift_d      = '0;
                            perr_acc_d   = 1'b0;
                            ferr_acc_d   = 1'b0;
                            cfg_frame_d  = frame_type;
                            cfg_parity_d = parity_type;
                            cfg_stop_d   = stop_type;
                        end else begin
                            state_d = STATE_RCVR_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rx_s;
                        if (idx_q == last_index(cfg_frame_q)) begin
                            state_d = parity_enabled(cfg_parity_q) ? PARITY : STOP1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = STOP1;
                        // shift_q holds zeros above the frame width, so a full XOR is exact.
                        perr_acc_d = (^shift_q ^ rx_s) ^ (cfg_parity_q == PARITY_ODD);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP1: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        ferr_acc_d = !rx_s;
                        if (cfg_stop_q == STOP_TWO) begin
                            state_d = STOP2;
                        end else begin
                            finish   = 1'b1;
                            ferr_fin = !rx_s;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP2: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        finish   = 1'b1;
                        ferr_fin = ferr_acc_q | !rx_s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = STATE_RCVR_IDLE;
                    cnt_d   = '0;
                end
            endcase

            // A low final stop sample means a break may be in progress: stay disarmed.
            if (finish) begin
                state_d = STATE_RCVR_IDLE;
                data_d  = shift_q;
                perr_d  = perr_acc_q;
                ferr_d  = ferr_fin;
                done_d  = 1'b1;
                armed_d = rx_s;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= STATE_RCVR_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            cfg_frame_q  <= '0;
            cfg_parity_q <= '0;
            cfg_stop_q   <= 1'b0;
            perr_acc_q   <= 1'b0;
            ferr_acc_q   <= 1'b0;
            armed_q      <= 1'b0;
            data_q       <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            cfg_frame_q  <= cfg_frame_d;
            cfg_parity_q <= cfg_parity_d;
            cfg_stop_q   <= cfg_stop_d;
            perr_acc_q   <= perr_acc_d;
            ferr_acc_q   <= ferr_acc_d;
            armed_q      <= armed_d;
            data_q       <= data_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            done_q       <= done_d;
        end
    end

    assign data       = data_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign done       = done_q & active;
    assign busy       = (state_q != STATE_RCVR_IDLE);

endmodule

// File: tb/tb_uart_rcvr.sv
// Randomised scoreboard bench for uart_rcvr: frames are built from their format rules, the
// expected word and flags are queued, and a forked monitor checks every done strobe.
module tb_uart_rcvr;

    localparam int unsigned OS = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       active;
    logic       rcvr_clk_en;
    logic       rcvr_clr;
    logic       rx;
    logic [1:0] frame_type;
    logic [1:0] parity_type;
    logic       stop_type;
    logic [7:0] data;
    logic       done;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    uart_rcvr #(
        .OVERSAMPLE(OS)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .active     (active),
        .rcvr_clk_en(rcvr_clk_en),
        .rcvr_clr   (rcvr_clr),
        .rx         (rx),
        .frame_type (frame_type),
        .parity_type(parity_type),
        .stop_type  (stop_type),
        .data       (data),
        .done       (done),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial forever #5 clk = ~clk;

    // One oversample tick every third clock.
    initial begin
        rcvr_clk_en = 1'b0;
        forever begin
            repeat (2) @(negedge clk);
            rcvr_clk_en = 1'b1;
            @(negedge clk);
            rcvr_clk_en = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!rcvr_clk_en);
        end
        #1;
    endtask

    // Expected result of one frame, derived from what was put on the line.
    function automatic exp_t model(input logic [7:0] d, input logic [1:0] ft, input logic [1:0] pt,
                                   input logic st, input logic par_flip,
                                   input logic [1:0] stop_bad);
        exp_t e;
        int   nbits = 5 + int'(ft);
        e.d  = d & 8'((1 << nbits) - 1);
        e.pe = (pt == 2'b01 || pt == 2'b10) && par_flip;
        e.fe = stop_bad[0] || (st && stop_bad[1]);
        return e;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [1:0] ft, input logic [1:0] pt,
                              input logic st, input logic par_flip, input logic [1:0] stop_bad,
                              input logic scramble);
        int         nbits = 5 + int'(ft);
        logic [7:0] w     = d & 8'((1 << nbits) - 1);
        frame_type  = ft;
        parity_type = pt;
        stop_type   = st;
        sb.push_back(model(d, ft, pt, st, par_flip, stop_bad));
        rx = 1'b0;
        wait_ticks(OS);
        if (scramble) begin
            frame_type  = 2'($urandom);
            parity_type = 2'($urandom);
            stop_type   = 1'($urandom);
        end
        for (int i = 0; i < nbits; i++) begin
            rx = w[i];
            wait_ticks(OS);
        end
        if (pt == 2'b01 || pt == 2'b10) begin
            rx = ((pt == 2'b10) ? ~^w : ^w) ^ par_flip;
            wait_ticks(OS);
        end
        rx = ~stop_bad[0];
        wait_ticks(OS);
        if (st) begin
            rx = ~stop_bad[1];
            wait_ticks(OS);
        end
        rx          = 1'b1;
        frame_type  = ft;
        parity_type = pt;
        stop_type   = st;
    endtask

    task automatic monitor_loop();
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                check("done_active", 32'(active), 32'd1);
                check("done_width", 32'(prev_done), 32'd0);
                check("sb_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("data", 32'(data), 32'(e.d));
                    check("parity_err", 32'(parity_err), 32'(e.pe));
                    check("frame_err", 32'(frame_err), 32'(e.fe));
                    check("busy_at_done", 32'(busy), 32'd0);
                end
            end
            prev_done = done;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [1:0] rft, rpt, rsb;
        logic       rst, rpf, last_bad;
        int         idle;
        int         t;

        arst_n      = 1'b0;
        active      = 1'b1;
        rcvr_clr    = 1'b0;
        rx          = 1'b1;
        frame_type  = 2'b11;
        parity_type = 2'b00;
        stop_type   = 1'b0;

        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        arst_n = 1'b1;
        wait_ticks(4);

        // Directed formats: 8N1, 7E2 good/bad parity, 5O1 with a bad stop bit.
        send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        wait_ticks(3);
        send_frame(8'h35, 2'b10, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0);
        wait_ticks(3);
        send_frame(8'h35, 2'b10, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0);
        wait_ticks(3);
        send_frame(8'h1F, 2'b00, 2'b10, 1'b0, 1'b0, 2'b01, 1'b0);
        wait_ticks(3);

        // Start glitch of four ticks.
        rx = 1'b0;
        wait_ticks(2);
        @(negedge clk);
        check("glitch_busy_hi", 32'(busy), 32'd1);
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(6);
        @(negedge clk);
        check("glitch_busy_lo", 32'(busy), 32'd0);
        wait_ticks(2);

        // Back-to-back 8N1 frames with no idle gap.
        send_frame(8'h12, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        send_frame(8'h34, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        wait_ticks(3);

        // rcvr_clr in the middle of the data bits.
        rx = 1'b0;
        wait_ticks(OS);
        rx = 1'b1;
        wait_ticks(OS);
        rx = 1'b0;
        wait_ticks(OS);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("clr_busy_before", 32'(busy), 32'd1);
        rcvr_clr = 1'b1;
        @(negedge clk);
        rcvr_clr = 1'b0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_data", 32'(data), 32'd0);
        check("clr_perr", 32'(parity_err), 32'd0);
        check("clr_ferr", 32'(frame_err), 32'd0);
        wait_ticks(OS * 10);

        // Dropping active mid-frame keeps the previous word.
        send_frame(8'h5C, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        wait_ticks(3);
        rx = 1'b0;
        wait_ticks(OS);
        rx = 1'b1;
        wait_ticks(OS * 2);
        @(negedge clk);
        active = 1'b0;
        @(negedge clk);
        check("inact_busy", 32'(busy), 32'd0);
        check("inact_data", 32'(data), 32'h5C);
        rx = 1'b0;
        wait_ticks(OS * 4);
        @(negedge clk);
        check("inact_no_start", 32'(busy), 32'd0);
        rx = 1'b1;
        wait_ticks(4);
        active = 1'b1;
        wait_ticks(4);

        // Break: one all-zero frame with a framing error, then no restart while rx stays low.
        frame_type  = 2'b11;
        parity_type = 2'b00;
        stop_type   = 1'b0;
        sb.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
        rx = 1'b0;
        wait_ticks(OS * 12);
        wait_ticks(OS * 5);
        @(negedge clk);
        check("break_idle", 32'(busy), 32'd0);
        check("break_pending", 32'(sb.size()), 32'd0);
        rx = 1'b1;
        wait_ticks(3);
        send_frame(8'h81, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        wait_ticks(3);

        // Random formats, errors and gaps; config inputs are scrambled mid-frame.
        for (int n = 0; n < 30; n++) begin
            rd   = 8'($urandom);
            rft  = 2'($urandom);
            rpt  = 2'($urandom);
            rst  = 1'($urandom);
            rpf  = ($urandom_range(0, 3) == 0);
            rsb  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            send_frame(rd, rft, rpt, rst, rpf, rsb, 1'b1);
            last_bad = rst ? rsb[1] : rsb[0];
            idle     = $urandom_range(0, 6);
            if (last_bad && idle < 2) idle = 2;
            if (idle > 0) wait_ticks(idle);
        end

        t = 0;
        while (sb.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
